// File: rtl/rook_path_checker.sv
// Sequential rook-move legality checker: validates geometry, then walks the
// path square by square through the board RAM read port.
module rook_path_checker #(
  parameter logic [4:0] ROOK_W_A = 5'd13,
  parameter logic [4:0] ROOK_W_H = 5'd14,
  parameter logic [4:0] ROOK_B_A = 5'd29,
  parameter logic [4:0] ROOK_B_H = 5'd30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] src_sq,
  input  logic [5:0] dst_sq,
  input  logic       side,
  output logic       mem_en,
  output logic [5:0] mem_addr,
  input  logic [4:0] mem_rdata,
  output logic       resp_valid,
  output logic       resp_legal,
  output logic       resp_capture,
  output logic [1:0] resp_reason
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_CHECK, S_DONE} state_t;
  typedef enum logic [1:0] {RSN_OK, RSN_GEOM, RSN_SRC, RSN_BLOCKED} reason_t;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_src;
  logic [5:0] r_dst;
  logic       r_side;
  logic [5:0] r_ptr;
  logic       r_legal;
  logic       r_capture;
  reason_t    r_reason;

  logic       w_same_rank;
  logic       w_same_file;
  logic       w_geom_bad;
  logic [5:0] w_step;
  logic       w_is_white;
  logic       w_is_black;
  logic       w_own;
  logic       w_enemy;
  logic       w_own_rook;
  logic       w_fin;
  reason_t    w_fin_reason;
  logic       w_fin_capture;

  assign w_same_rank = (r_src[5:3] == r_dst[5:3]);
  assign w_same_file = (r_src[2:0] == r_dst[2:0]);
  assign w_geom_bad  = (r_src == r_dst) || (!w_same_rank && !w_same_file);
  // Negative steps are two's-complement 6-bit values (63 = -1, 56 = -8).
  assign w_step = w_same_rank ? ((r_dst > r_src) ? 6'd1 : 6'd63)
                              : ((r_dst > r_src) ? 6'd8 : 6'd56);

  assign w_is_white = (mem_rdata != 5'd0) && (mem_rdata <= 5'd16);
  assign w_is_black = (mem_rdata >= 5'd17);
  assign w_own      = r_side ? w_is_black : w_is_white;
  assign w_enemy    = r_side ? w_is_white : w_is_black;
  assign w_own_rook = r_side ? ((mem_rdata == ROOK_B_A) || (mem_rdata == ROOK_B_H))
                             : ((mem_rdata == ROOK_W_A) || (mem_rdata == ROOK_W_H));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    mem_en        = 1'b0;
    resp_valid    = 1'b0;
    w_fin         = 1'b0;
    w_fin_reason  = RSN_OK;
    w_fin_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_SETUP;
      end
      S_SETUP: begin
        if (w_geom_bad) begin
          w_fin        = 1'b1;
          w_fin_reason = RSN_GEOM;
          w_next       = S_DONE;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en = 1'b1;
        w_next = S_CHECK;
      end
      S_CHECK: begin
        if (r_ptr == r_src) begin
          if (w_own_rook) begin
            w_next = S_ISSUE;
          end else begin
            w_fin        = 1'b1;
            w_fin_reason = RSN_SRC;
            w_next       = S_DONE;
          end
        end else if (r_ptr == r_dst) begin
          w_fin         = 1'b1;
          w_fin_reason  = w_own ? RSN_BLOCKED : RSN_OK;
          w_fin_capture = w_enemy;
          w_next        = S_DONE;
        end else if (mem_rdata != 5'd0) begin
          w_fin        = 1'b1;
          w_fin_reason = RSN_BLOCKED;
          w_next       = S_DONE;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Result registers load only on entry to DONE, so they hold between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_side    <= 1'b0;
      r_ptr     <= '0;
      r_legal   <= 1'b0;
      r_capture <= 1'b0;
      r_reason  <= RSN_OK;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_src  <= src_sq;
        r_dst  <= dst_sq;
        r_side <= side;
      end
      if (r_state == S_SETUP) r_ptr <= r_src;
      if (r_state == S_CHECK && w_next == S_ISSUE) r_ptr <= r_ptr + w_step;
      if (w_fin) begin
        r_legal   <= (w_fin_reason == RSN_OK);
        r_capture <= w_fin_capture;
        r_reason  <= w_fin_reason;
      end
    end
  end

  assign mem_addr     = r_ptr;
  assign resp_legal   = r_legal;
  assign resp_capture = r_capture;
  assign resp_reason  = r_reason;

endmodule
